// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared definitions for the IRQ request controller slice.
//   - Default line count and default sizing parameters.
//   - Helper functions that derive the debounce counter width and the
//     pending-counter saturation value from the block parameters.
//   - Encoding of the per-line pending-counter update.
// -----------------------------------------------------------------------------
package irq_pkg;

   localparam int N_IRQ_DEFAULT           = 3;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
   localparam int CNT_WIDTH_DEFAULT       = 4;

   // Per-line pending counter update selected in one clock.
   typedef enum logic [1:0] {
      PEND_HOLD = 2'd0,   // no change
      PEND_INC  = 2'd1,   // new request queued
      PEND_DEC  = 2'd2,   // one request acknowledged
      PEND_DROP = 2'd3    // request lost to saturation, raise overflow
   } pend_op_e;

   // Width of a counter that counts 0 .. cycles-1. Never below one bit.
   function automatic int deb_cnt_width(input int cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

   // Largest value a width-bit pending counter can hold.
   function automatic int sat_count(input int width);
      return (1 << width) - 1;
   endfunction

   // A press and an ack in the same cycle cancel out: the ack frees the slot
   // the press needs, so even a saturated counter does not flag overflow.
   // An ack with nothing pending is simply ignored.
   function automatic pend_op_e pend_decode(input logic press,
                                            input logic ack,
                                            input logic at_sat,
                                            input logic at_zero);
      pend_op_e op;
      op = PEND_HOLD;
      if (press && !ack) begin
         op = at_sat ? PEND_DROP : PEND_INC;
      end else if (!press && ack && !at_zero) begin
         op = PEND_DEC;
      end
      return op;
   endfunction

endpackage

// File: rtl/irq_request_ctrl_if.sv
// -----------------------------------------------------------------------------
// irq_request_ctrl_if
// Bundle between the button/CPU side and the IRQ request controller.
//   BTN     : raw button levels, asynchronous, active-high      (master -> slave)
//   IRW     : CPU acknowledge pulses, one per consumed request  (master -> slave)
//   IRQ     : request level per line, high while pending != 0  (slave -> master)
//   pending : concatenated per-line pending counts, line 0 LSBs (slave -> master)
//   ovf     : sticky per-line dropped-press flag                (slave -> master)
// master = buttons plus CPU, slave = irq_request_ctrl.
// -----------------------------------------------------------------------------
interface irq_request_ctrl_if
   import irq_pkg::*;
#(
   parameter int N_IRQ     = N_IRQ_DEFAULT,
   parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) ();

   logic [N_IRQ-1:0]           BTN;
   logic [N_IRQ-1:0]           IRW;
   logic [N_IRQ-1:0]           IRQ;
   logic [N_IRQ*CNT_WIDTH-1:0] pending;
   logic [N_IRQ-1:0]           ovf;

   modport master (
      output BTN,
      output IRW,
      input  IRQ,
      input  pending,
      input  ovf
   );

   modport slave (
      input  BTN,
      input  IRW,
      output IRQ,
      output pending,
      output ovf
   );

endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One button line: two-flop synchroniser, debounce counter, debounced level
// and a single-cycle press pulse.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   btn_raw : raw button level, asynchronous to clk
//   press   : high for the one cycle whose closing edge flips the debounced
//             level 0->1; release produces nothing
// -----------------------------------------------------------------------------
module btn_debounce
   import irq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);

   localparam int            CW   = deb_cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_reg;
   logic          sync2_reg;
   logic          stable_reg;
   logic [CW-1:0] cnt_reg;

   // fill_reg marks when sync2 holds a genuine sample of the button rather
   // than its reset value. armed_reg is set once the line has been seen
   // released after reset, so a button already held down through a reset
   // does not turn into a request until it is released and pressed again.
   logic [1:0]    fill_reg;
   logic          armed_reg;

   logic          accept;

   // The debounced level changes at this edge.
   assign accept = (sync2_reg != stable_reg) && (cnt_reg == LAST);

   // Combinational from registers so the pending counter moves on the very
   // edge that sets the debounced level high.
   assign press  = accept && sync2_reg && armed_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg  <= 1'b0;
         sync2_reg  <= 1'b0;
         stable_reg <= 1'b0;
         cnt_reg    <= '0;
         fill_reg   <= 2'b00;
         armed_reg  <= 1'b0;
      end else begin
         sync1_reg <= btn_raw;
         sync2_reg <= sync1_reg;
         fill_reg  <= {fill_reg[0], 1'b1};

         if (fill_reg[1] && !sync2_reg && !stable_reg) begin
            armed_reg <= 1'b1;
         end

         if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
         end else if (accept) begin
            stable_reg <= sync2_reg;
            cnt_reg    <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_request_ctrl.sv
// -----------------------------------------------------------------------------
// irq_request_ctrl
// Turns bouncy asynchronous buttons into queued interrupt requests for the
// CPU. Each debounced press queues one request on its line; the line's IRQ
// stays high until every queued request has been consumed by an IRW pulse.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset; clears all queued requests
//   bus : irq_request_ctrl_if.slave
//         BTN in, IRW in, IRQ out, pending out, ovf out
// Lines are fully independent; prioritisation is left to the CPU.
// -----------------------------------------------------------------------------
module irq_request_ctrl
   import irq_pkg::*;
#(
   parameter int N_IRQ           = N_IRQ_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_WIDTH       = CNT_WIDTH_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   irq_request_ctrl_if.slave  bus
);

   localparam logic [CNT_WIDTH-1:0] SAT = CNT_WIDTH'(sat_count(CNT_WIDTH));

   logic [N_IRQ-1:0] press;

   generate
      for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_line
         logic [CNT_WIDTH-1:0] pend_reg;
         logic                 ovf_reg;
         pend_op_e             op;

         btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (bus.BTN[gi]),
            .press   (press[gi])
         );

         assign op = pend_decode(press[gi], bus.IRW[gi],
                                 pend_reg == SAT, pend_reg == '0);

         // ovf is sticky: only reset clears it.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pend_reg <= '0;
               ovf_reg  <= 1'b0;
            end else begin
               case (op)
                  PEND_INC:  pend_reg <= pend_reg + 1'b1;
                  PEND_DEC:  pend_reg <= pend_reg - 1'b1;
                  PEND_DROP: ovf_reg  <= 1'b1;
                  default:   ;
               endcase
            end
         end

         // IRQ decodes straight from the registered count, so a count going
         // 1->0 on an ack edge drops the line right after that edge.
         assign bus.IRQ[gi]                              = |pend_reg;
         assign bus.pending[gi*CNT_WIDTH +: CNT_WIDTH]   = pend_reg;
         assign bus.ovf[gi]                              = ovf_reg;
      end
   endgenerate

endmodule

// File: tb/tb_irq_request_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_request_ctrl
// Directed scenarios against hand-derived values, then a randomized run
// against a behavioural model of the press/ack queueing rules.
// -----------------------------------------------------------------------------
module tb_irq_request_ctrl;

   localparam int N    = 3;
   localparam int DC   = 4;
   localparam int CW   = 4;
   localparam int MAXC = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   irq_request_ctrl_if #(.N_IRQ(N), .CNT_WIDTH(CW)) bus ();

   irq_request_ctrl #(
      .N_IRQ           (N),
      .DEBOUNCE_CYCLES (DC),
      .CNT_WIDTH       (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- behavioural reference model ----------------
   // A level is accepted once the button, seen through a two-sample delay,
   // has disagreed with the accepted level for DC consecutive edges. A press
   // is a 0->1 acceptance on a line that has been seen released since reset.
   int          m_cnt    [N];
   bit          m_ovf    [N];
   bit          m_stable [N];
   int          m_run    [N];
   bit          m_armed  [N];
   logic [N-1:0] btn_q [$];

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_cnt[i] = 0; m_ovf[i] = 0; m_stable[i] = 0; m_run[i] = 0; m_armed[i] = 0;
      end
      btn_q.delete();
   endtask

   task automatic model_edge();
      logic [N-1:0] d;
      bit valid, press, ack, old_stable;
      valid = (btn_q.size() >= 2);
      d = valid ? btn_q[btn_q.size()-2] : '0;
      for (int i = 0; i < N; i++) begin
         old_stable = m_stable[i];
         press = 1'b0;
         if (d[i] != m_stable[i]) m_run[i]++;
         else m_run[i] = 0;
         if (m_run[i] == DC) begin
            m_stable[i] = d[i];
            m_run[i] = 0;
            press = d[i] && m_armed[i];
         end
         if (valid && !d[i] && !old_stable) m_armed[i] = 1'b1;
         ack = bus.IRW[i];
         if (press && !ack) begin
            if (m_cnt[i] == MAXC) m_ovf[i] = 1'b1;
            else m_cnt[i]++;
         end else if (!press && ack && m_cnt[i] > 0) begin
            m_cnt[i]--;
         end
      end
      btn_q.push_back(bus.BTN);
      if (btn_q.size() > 4) void'(btn_q.pop_front());
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_edge();
      end
   end

   function automatic logic [N*CW-1:0] exp_pending();
      logic [N*CW-1:0] r;
      for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'(m_cnt[i]);
      return r;
   endfunction

   function automatic logic [N-1:0] exp_irq();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = (m_cnt[i] != 0);
      return r;
   endfunction

   function automatic logic [N-1:0] exp_ovf();
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = m_ovf[i];
      return r;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   // Clean press on every line in mask: held, then released long enough for
   // the release to be accepted before anything else happens.
   task automatic press_lines(input logic [N-1:0] mask);
      bus.BTN = bus.BTN | mask;
      repeat (8) tick();
      bus.BTN = bus.BTN & ~mask;
      repeat (10) tick();
      $display("[%0t] press mask=%b pending=%h irq=%b", $time, mask, bus.pending, bus.IRQ);
   endtask

   task automatic ack_line(input int i);
      bus.IRW[i] = 1'b1;
      tick();
      bus.IRW[i] = 1'b0;
      $display("[%0t] ack line=%0d pending=%h irq=%b", $time, i, bus.pending, bus.IRQ);
   endtask

   // Press whose acceptance edge coincides with an ack on the same line.
   task automatic press_with_ack(input int i);
      bus.BTN[i] = 1'b1;
      repeat (DC+1) tick();
      bus.IRW[i] = 1'b1;
      tick();
      bus.IRW[i] = 1'b0;
      $display("[%0t] press+ack line=%0d pending=%h", $time, i, bus.pending);
      repeat (4) tick();
      bus.BTN[i] = 1'b0;
      repeat (10) tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      bus.BTN = '0;
      bus.IRW = '0;
      repeat (2) tick();
      n_cmp++; if (bus.IRQ !== '0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", bus.IRQ); end
      n_cmp++; if (bus.pending !== '0) begin n_bad++; $display("FAIL reset_pending: got %h want 0", bus.pending); end
      n_cmp++; if (bus.ovf !== '0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
      rst = 1'b0;
      repeat (6) tick();
      n_cmp++; if (bus.pending !== '0) begin n_bad++; $display("FAIL idle_pending: got %h want 0", bus.pending); end
      $display("[%0t] reset released", $time);
   endtask

   task automatic test_clean_press();
      bus.BTN[0] = 1'b1;
      repeat (DC+1) tick();
      n_cmp++; if (bus.IRQ[0] !== 1'b0) begin n_bad++; $display("FAIL clean_early_irq: got %b want 0", bus.IRQ[0]); end
      tick();
      n_cmp++; if (bus.IRQ[0] !== 1'b1) begin n_bad++; $display("FAIL clean_irq: got %b want 1", bus.IRQ[0]); end
      n_cmp++; if (bus.pending[3:0] !== 4'd1) begin n_bad++; $display("FAIL clean_pending: got %0d want 1", bus.pending[3:0]); end
      repeat (14) tick();
      bus.BTN[0] = 1'b0;
      repeat (10) tick();
      n_cmp++; if (bus.pending[3:0] !== 4'd1) begin n_bad++; $display("FAIL clean_held_once: got %0d want 1", bus.pending[3:0]); end
      ack_line(0);
      n_cmp++; if (bus.IRQ[0] !== 1'b0) begin n_bad++; $display("FAIL clean_ack_irq: got %b want 0", bus.IRQ[0]); end
      tick();
   endtask

   task automatic test_bounce();
      logic pat [14];
      int bad_cycles;
      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      bad_cycles = 0;
      for (int k = 0; k < 14; k++) begin
         bus.BTN[1] = pat[k];
         tick();
         n_cmp++;
         if (bus.pending[7:4] !== 4'd0 || bus.IRQ[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL bounce_ignored: cycle %0d pending=%0d irq=%b want 0/0", k, bus.pending[7:4], bus.IRQ[1]);
         end
      end
      bus.BTN[1] = 1'b1;
      repeat (6) tick();
      bus.BTN[1] = 1'b0;
      repeat (10) tick();
      n_cmp++; if (bus.pending[7:4] !== 4'd1) begin n_bad++; $display("FAIL bounce_six_high: got %0d want 1", bus.pending[7:4]); end
      ack_line(1);
      n_cmp++; if (bus.pending[7:4] !== 4'd0) begin n_bad++; $display("FAIL bounce_ack: got %0d want 0", bus.pending[7:4]); end
      tick();
   endtask

   task automatic test_queue();
      repeat (3) press_lines(3'b100);
      n_cmp++; if (bus.pending[11:8] !== 4'd3) begin n_bad++; $display("FAIL queue_count: got %0d want 3", bus.pending[11:8]); end
      n_cmp++; if (bus.IRQ[2] !== 1'b1) begin n_bad++; $display("FAIL queue_irq: got %b want 1", bus.IRQ[2]); end
      for (int k = 2; k >= 0; k--) begin
         ack_line(2);
         n_cmp++;
         if (bus.pending[11:8] !== 4'(k) || bus.IRQ[2] !== (k != 0)) begin
            n_bad++;
            $display("FAIL queue_drain: pending=%0d irq=%b want %0d/%b", bus.pending[11:8], bus.IRQ[2], k, (k != 0));
         end
         tick();
      end
   endtask

   task automatic test_saturation();
      repeat (15) press_lines(3'b001);
      n_cmp++; if (bus.pending[3:0] !== 4'd15) begin n_bad++; $display("FAIL sat_fill: got %0d want 15", bus.pending[3:0]); end
      n_cmp++; if (bus.ovf[0] !== 1'b0) begin n_bad++; $display("FAIL sat_no_ovf_yet: got %b want 0", bus.ovf[0]); end
      press_lines(3'b001);
      n_cmp++; if (bus.pending[3:0] !== 4'd15) begin n_bad++; $display("FAIL sat_hold: got %0d want 15", bus.pending[3:0]); end
      n_cmp++; if (bus.ovf[0] !== 1'b1) begin n_bad++; $display("FAIL sat_ovf: got %b want 1", bus.ovf[0]); end
      press_with_ack(0);
      n_cmp++; if (bus.pending[3:0] !== 4'd15) begin n_bad++; $display("FAIL sat_press_ack: got %0d want 15", bus.pending[3:0]); end
      ack_line(0);
      n_cmp++; if (bus.pending[3:0] !== 4'd14) begin n_bad++; $display("FAIL sat_lone_ack: got %0d want 14", bus.pending[3:0]); end
      n_cmp++; if (bus.ovf[0] !== 1'b1) begin n_bad++; $display("FAIL sat_ovf_sticky: got %b want 1", bus.ovf[0]); end
      tick();
   endtask

   task automatic test_ack_empty();
      ack_line(1);
      n_cmp++; if (bus.pending[7:4] !== 4'd0) begin n_bad++; $display("FAIL empty_ack_count: got %0d want 0", bus.pending[7:4]); end
      n_cmp++; if (bus.ovf[1] !== 1'b0) begin n_bad++; $display("FAIL empty_ack_ovf: got %b want 0", bus.ovf[1]); end
      tick();
      press_lines(3'b010);
      n_cmp++; if (bus.pending[7:4] !== 4'd1) begin n_bad++; $display("FAIL coincide_pre: got %0d want 1", bus.pending[7:4]); end
      press_with_ack(1);
      n_cmp++; if (bus.pending[7:4] !== 4'd1) begin n_bad++; $display("FAIL coincide_count: got %0d want 1", bus.pending[7:4]); end
      n_cmp++; if (bus.ovf[1] !== 1'b0) begin n_bad++; $display("FAIL coincide_ovf: got %b want 0", bus.ovf[1]); end
   endtask

   task automatic reset_pulse();
      #1 rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.IRQ !== '0 || bus.pending !== '0 || bus.ovf !== '0) begin
         n_bad++;
         $display("FAIL async_reset: irq=%b pending=%h ovf=%b want all 0", bus.IRQ, bus.pending, bus.ovf);
      end
      #1 rst = 1'b0;
      $display("[%0t] async reset pulse", $time);
      tick();
   endtask

   task automatic test_reset_mid();
      reset_pulse();
      repeat (4) tick();
      press_lines(3'b111);
      press_lines(3'b101);
      press_lines(3'b100);
      n_cmp++; if (bus.pending !== 12'h312) begin n_bad++; $display("FAIL mid_build: got %h want 312", bus.pending); end
      bus.BTN[0] = 1'b1;
      repeat (3) tick();
      reset_pulse();
      for (int k = 0; k < 20; k++) begin
         tick();
         n_cmp++;
         if (bus.pending[3:0] !== 4'd0) begin
            n_bad++;
            $display("FAIL held_no_event: cycle %0d got %0d want 0", k, bus.pending[3:0]);
         end
      end
      bus.BTN[0] = 1'b0;
      repeat (10) tick();
      press_lines(3'b001);
      n_cmp++; if (bus.pending[3:0] !== 4'd1) begin n_bad++; $display("FAIL repress_after_reset: got %0d want 1", bus.pending[3:0]); end
   endtask

   task automatic test_random();
      int seg [N];
      logic lvl [N];
      for (int i = 0; i < N; i++) begin seg[i] = 0; lvl[i] = 1'b0; end
      for (int c = 0; c < 1500; c++) begin
         tick();
         n_cmp++;
         if (bus.pending !== exp_pending()) begin
            n_bad++; $display("FAIL rand_pending: cycle %0d got %h want %h", c, bus.pending, exp_pending());
         end
         n_cmp++;
         if (bus.IRQ !== exp_irq()) begin
            n_bad++; $display("FAIL rand_irq: cycle %0d got %b want %b", c, bus.IRQ, exp_irq());
         end
         n_cmp++;
         if (bus.ovf !== exp_ovf()) begin
            n_bad++; $display("FAIL rand_ovf: cycle %0d got %b want %b", c, bus.ovf, exp_ovf());
         end
         for (int i = 0; i < N; i++) begin
            if (seg[i] == 0) begin
               lvl[i] = 1'($urandom_range(0, 1));
               seg[i] = $urandom_range(1, 10);
            end
            seg[i]--;
            bus.BTN[i] = lvl[i];
            bus.IRW[i] = ($urandom_range(0, 9) == 0);
         end
         if (c % 100 == 99)
            $display("[%0t] random cycle %0d pending=%h ovf=%b", $time, c, bus.pending, bus.ovf);
      end
      bus.BTN = '0;
      bus.IRW = '0;
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_queue();
      test_saturation();
      test_ack_empty();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/irq_request_ctrl.md
Name: irq_request_ctrl

Overview:
- Upstream feeder for the interrupt-pipeline CPU's IRQ inputs.
- Takes raw, asynchronous, bouncy button lines and synchronises and debounces each one.
- Converts each debounced press into a queued interrupt request. Holds the CPU's IRQ line high until every queued request on that line has been acknowledged via the CPU's IRW pulses.
- Replaces hand-driven IRQ stimulus in benches and on the board.

Parameters:
- N_IRQ, 3, number of interrupt lines (matches CPU IRQ/IRW width).
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a level change; legal range 2..2^16.
- CNT_WIDTH, 4, width of each per-line pending-request counter; saturates at 2^CNT_WIDTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- BTN  in  N_IRQ  raw button levels, asynchronous to clk, active-high.
- IRW  in  N_IRQ  acknowledge from CPU; a one-cycle high pulse on bit i consumes one pending request on line i.
- IRQ  out  N_IRQ  request level to CPU; bit i = (pending[i] != 0).
- pending  out  N_IRQ*CNT_WIDTH  concatenated per-line pending counts, line 0 in LSBs (debug/LED).
- ovf  out  N_IRQ  sticky per-line flag: a press was dropped because the counter was saturated.

Behaviour:
- Reset (async, rst=1):
  - sync flops, debounced "stable" levels and debounce counters all go to 0.
  - pending, IRQ and ovf all go to 0.
  - Takes effect mid-operation too; queued requests are lost.
- Synchroniser: two flops per line (sync1, sync2).
- Debounce, per line, clocked on clk:
  - If sync2 == stable: debounce counter cleared.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= sync2 and counter cleared.
  - Else: counter increments.
  - Consequence: any excursion shorter than DEBOUNCE_CYCLES sync2-cycles is ignored.
- Press event: a single-cycle pulse, asserted in the cycle where stable flips 0->1. Release (1->0) produces no event.
- Latency: BTN high and sampled at edge E0, held steady → stable=1, pending increments and IRQ goes high after edge E0+DEBOUNCE_CYCLES+1 (i.e. DEBOUNCE_CYCLES+2 edges). Exactly one request per press, however long the button is held.
- Pending counter, per line, evaluated in the same edge:
  - press & !ack: +1 if not saturated; if saturated, count unchanged and ovf[i] <= 1.
  - !press & ack: -1 if nonzero; ack with count 0 is ignored (no underflow, no flag).
  - press & ack: count unchanged, including at saturation. A simultaneous ack frees a slot, so ovf is not set.
  - neither: hold.
- IRQ and ack timing:
  - IRQ is combinational from the registered count, so no extra latency.
  - An ack at edge E drops IRQ after E when the count goes 1->0.
  - A multi-cycle IRW high is treated as one ack per cycle high.
- ovf clears only on reset.
- Lines are fully independent; no priority encoding here (the CPU prioritises).

Decomposition:
- Shared package irq_pkg holds:
  - N_IRQ default.
  - Debounce counter width, computed as clog2(DEBOUNCE_CYCLES).
  - Saturation constant, computed as (1<<CNT_WIDTH)-1.
- Sub-module btn_debounce contains the 2-flop sync, debounce counter, stable level and press pulse for one line. It is instantiated N_IRQ times via generate.
- Top level holds the pending counters, IRQ decode and ovf.

Test Plan (DEBOUNCE_CYCLES=4, CNT_WIDTH=4):
- Clean press: BTN[0] 0→1 sampled at edge 10, held 20 cycles → IRQ[0]=1 after edge 15, pending[0]=1. Then one IRW[0] pulse → IRQ[0]=0 next edge.
- Bounce rejection: BTN[1] toggles high 1 cycle, low 1, high 2, low → pending[1]=0, IRQ[1]=0 throughout. A following 6-cycle high → exactly one request.
- Queueing: three separate presses on line 2 with no acks → pending[2]=3 and IRQ[2] high. Then three single-cycle acks → 2,1,0, with IRQ[2] low after the third ack.
- Saturation: 16 presses on line 0 without ack → pending[0]=15 and ovf[0]=1. A further press+ack in the same cycle → count stays 15. A lone ack → 14; ovf[0] stays 1.
- Ack on empty and press+ack coincidence: IRW[1] pulse with pending[1]=0 → stays 0, ovf[1]=0. With pending[1]=1, press event coincident with ack → count stays 1.
- Async reset mid-operation: pending=(2,1,3) and a debounce in progress; rst pulsed 2 ns between clk edges → all outputs 0 immediately. The held button generates no spurious event until it is released and pressed again.
